// File: rtl/cond_exec_stage.sv
// Execute-stage condition check and Execute->Memory pipeline register.
// Holds the architectural NZCV flags and gates write enables by the condition result.
module cond_exec_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   CondE,
    input  logic [1:0]   FlagWriteE,
    input  logic [3:0]   ALUFlags,
    input  logic [N-1:0] ALUResultE,
    input  logic [N-1:0] WriteDataE,
    input  logic [3:0]   WA3E,
    input  logic         PCSrcE,
    input  logic         RegWriteE,
    input  logic         MemWriteE,
    input  logic         MemtoRegE,
    input  logic         BranchE,
    input  logic         StallM,
    input  logic         FlushM,
    output logic         BranchTakenE,
    output logic         CondExE,
    output logic         PCSrcM,
    output logic         RegWriteM,
    output logic         MemWriteM,
    output logic         MemtoRegM,
    output logic [N-1:0] ALUResultM,
    output logic [N-1:0] WriteDataM,
    output logic [3:0]   WA3M,
    output logic [3:0]   FlagsQ
);

    logic [3:0]   flags_q, flags_d;
    logic         pcsrc_q, regwrite_q, memwrite_q, memtoreg_q;
    logic         pcsrc_d, regwrite_d, memwrite_d;
    logic [N-1:0] aluresult_q, writedata_q;
    logic [3:0]   wa3_q;

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ex;
    logic advance;
    logic update_en;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Conditions look only at stored flags, so a compare feeds the next instruction without a stall.
    always_comb begin
        cond_ex = 1'b1;
        case (CondE)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end

    assign CondExE      = cond_ex;
    assign BranchTakenE = BranchE & cond_ex & ~FlushM;

    assign advance   = ~StallM & ~FlushM;
    assign update_en = cond_ex & advance & ~reset;

    // Per-pair muxing keeps unselected ALU flag bits (possibly X) out of the register.
    always_comb begin
        flags_d = flags_q;
        if (update_en && FlagWriteE[1]) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (update_en && FlagWriteE[0]) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_comb begin
        pcsrc_d    = PCSrcE    & cond_ex;
        regwrite_d = RegWriteE & cond_ex;
        memwrite_d = MemWriteE & cond_ex;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q     <= 4'b0000;
            pcsrc_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            aluresult_q <= '0;
            writedata_q <= '0;
            wa3_q       <= 4'b0000;
        end else begin
            flags_q <= flags_d;
            if (FlushM) begin
                // Bubble: kill controls, leave datapath as is.
                pcsrc_q    <= 1'b0;
                regwrite_q <= 1'b0;
                memwrite_q <= 1'b0;
                memtoreg_q <= 1'b0;
            end else if (!StallM) begin
                pcsrc_q     <= pcsrc_d;
                regwrite_q  <= regwrite_d;
                memwrite_q  <= memwrite_d;
                memtoreg_q  <= MemtoRegE;
                aluresult_q <= ALUResultE;
                writedata_q <= WriteDataE;
                wa3_q       <= WA3E;
            end
        end
    end

    assign FlagsQ     = flags_q;
    assign PCSrcM     = pcsrc_q;
    assign RegWriteM  = regwrite_q;
    assign MemWriteM  = memwrite_q;
    assign MemtoRegM  = memtoreg_q;
    assign ALUResultM = aluresult_q;
    assign WriteDataM = writedata_q;
    assign WA3M       = wa3_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Bench for cond_exec_stage: directed vector table, X/sweep sequences, random run vs reference model.
module tb_cond_exec_stage;

    localparam int N = 32;

    logic         clk;
    logic         reset;
    logic [3:0]   CondE;
    logic [1:0]   FlagWriteE;
    logic [3:0]   ALUFlags;
    logic [N-1:0] ALUResultE, WriteDataE;
    logic [3:0]   WA3E;
    logic         PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE;
    logic         StallM, FlushM;
    logic         BranchTakenE, CondExE;
    logic         PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
    logic [N-1:0] ALUResultM, WriteDataM;
    logic [3:0]   WA3M, FlagsQ;

    int n_cmp = 0;
    int n_err = 0;

    cond_exec_stage #(.N(N)) dut (
        .clk(clk), .reset(reset), .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .BranchE(BranchE), .StallM(StallM), .FlushM(FlushM),
        .BranchTakenE(BranchTakenE), .CondExE(CondExE),
        .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M), .FlagsQ(FlagsQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [3:0]  cond;
        logic [1:0]  fw;
        logic [3:0]  af;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0]  wa3;
        logic [6:0]  ctl;    // {pcs, rw, mw, m2r, br, stall, flush}
        logic [2:0]  cmb;    // {check, CondExE, BranchTakenE}
        logic        chk_dp;
        logic [3:0]  x_flags;
        logic [3:0]  x_ctl;  // {PCSrcM, RegWriteM, MemWriteM, MemtoRegM}
        logic [31:0] x_alu;
        logic [31:0] x_wd;
        logic [3:0]  x_wa3;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] cond, input logic [1:0] fw,
                                input logic [3:0] af, input logic [31:0] alu, input logic [31:0] wd,
                                input logic [3:0] wa3, input logic [6:0] ctl, input logic [2:0] cmb,
                                input logic chk_dp, input logic [3:0] x_flags, input logic [3:0] x_ctl,
                                input logic [31:0] x_alu, input logic [31:0] x_wd, input logic [3:0] x_wa3);
        vec_t v;
        v.rst = rst; v.cond = cond; v.fw = fw; v.af = af; v.alu = alu; v.wd = wd; v.wa3 = wa3;
        v.ctl = ctl; v.cmb = cmb; v.chk_dp = chk_dp; v.x_flags = x_flags; v.x_ctl = x_ctl;
        v.x_alu = x_alu; v.x_wd = x_wd; v.x_wa3 = x_wa3;
        return v;
    endfunction

    // ARM-style: condition pairs share a base test, odd codes invert it, 111x always pass.
    function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond[3:1] == 3'd7) return 1'b1;
        return base ^ cond[0];
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] cond, input logic [1:0] fw,
                         input logic [3:0] af, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [3:0] wa3, input logic [6:0] ctl);
        reset = rst; CondE = cond; FlagWriteE = fw; ALUFlags = af;
        ALUResultE = alu; WriteDataE = wd; WA3E = wa3;
        {PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, StallM, FlushM} = ctl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  mf;
    logic [3:0]  m_ctl;
    logic [31:0] m_alu, m_wd;
    logic [3:0]  m_wa3;
    logic        m_dp_valid;

    initial begin
        drive(1'b1, 4'h0, 2'd0, 4'h0, 32'h0, 32'h0, 4'h0, 7'b0);
        #2;

        vecs.push_back(mk(1, 4'h0, 2'd0, 4'h0, 32'h0,    32'h0,  4'h0, 7'b0000000, 3'b000, 1, 4'h0, 4'b0000, 32'h0,    32'h0,  4'h0));
        vecs.push_back(mk(0, 4'hE, 2'd0, 4'h0, 32'h5,    32'hA,  4'h3, 7'b0100000, 3'b110, 1, 4'h0, 4'b0100, 32'h5,    32'hA,  4'h3));
        vecs.push_back(mk(0, 4'h1, 2'd0, 4'h0, 32'h7,    32'hB,  4'h2, 7'b0010000, 3'b110, 1, 4'h0, 4'b0010, 32'h7,    32'hB,  4'h2));
        vecs.push_back(mk(0, 4'hA, 2'd0, 4'h0, 32'h8,    32'hC,  4'h4, 7'b1000100, 3'b111, 1, 4'h0, 4'b1000, 32'h8,    32'hC,  4'h4));
        vecs.push_back(mk(0, 4'hE, 2'd3, 4'h4, 32'h0,    32'h0,  4'h0, 7'b0000000, 3'b110, 1, 4'h4, 4'b0000, 32'h0,    32'h0,  4'h0));
        vecs.push_back(mk(0, 4'h0, 2'd0, 4'h0, 32'h100,  32'h0,  4'hF, 7'b1000100, 3'b111, 1, 4'h4, 4'b1000, 32'h100,  32'h0,  4'hF));
        vecs.push_back(mk(0, 4'h1, 2'd3, 4'h8, 32'h9,    32'h99, 4'h9, 7'b0011000, 3'b100, 1, 4'h4, 4'b0001, 32'h9,    32'h99, 4'h9));
        vecs.push_back(mk(0, 4'hE, 2'd3, 4'h3, 32'h0,    32'h0,  4'h0, 7'b0000000, 3'b110, 1, 4'h3, 4'b0000, 32'h0,    32'h0,  4'h0));
        vecs.push_back(mk(0, 4'hE, 2'd2, 4'h8, 32'h0,    32'h0,  4'h0, 7'b0000000, 3'b110, 1, 4'hB, 4'b0000, 32'h0,    32'h0,  4'h0));
        vecs.push_back(mk(0, 4'hE, 2'd1, 4'h6, 32'h11,   32'h22, 4'h1, 7'b0100000, 3'b110, 1, 4'hA, 4'b0100, 32'h11,   32'h22, 4'h1));
        vecs.push_back(mk(0, 4'hE, 2'd3, 4'h0, 32'h55,   32'h56, 4'h5, 7'b0110010, 3'b110, 1, 4'hA, 4'b0100, 32'h11,   32'h22, 4'h1));
        vecs.push_back(mk(0, 4'h0, 2'd0, 4'h0, 32'h66,   32'h67, 4'h6, 7'b0100110, 3'b100, 1, 4'hA, 4'b0100, 32'h11,   32'h22, 4'h1));
        vecs.push_back(mk(0, 4'hE, 2'd3, 4'h0, 32'h70,   32'h71, 4'h7, 7'b1111111, 3'b110, 0, 4'hA, 4'b0000, 32'h0,    32'h0,  4'h0));
        vecs.push_back(mk(1, 4'hE, 2'd3, 4'hF, 32'h77,   32'h78, 4'h7, 7'b0100100, 3'b111, 1, 4'h0, 4'b0000, 32'h0,    32'h0,  4'h0));
        vecs.push_back(mk(0, 4'hA, 2'd0, 4'h0, 32'h1234, 32'h5678, 4'hC, 7'b1100100, 3'b111, 1, 4'h0, 4'b1100, 32'h1234, 32'h5678, 4'hC));
        vecs.push_back(mk(0, 4'h0, 2'd0, 4'h0, 32'hAB,   32'hCD, 4'hD, 7'b0100100, 3'b100, 1, 4'h0, 4'b0000, 32'hAB,   32'hCD, 4'hD));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst, v.cond, v.fw, v.af, v.alu, v.wd, v.wa3, v.ctl);
            #1;
            if (v.cmb[2]) begin
                chk("vec_condex", i, {31'd0, CondExE}, {31'd0, v.cmb[1]});
                chk("vec_branch", i, {31'd0, BranchTakenE}, {31'd0, v.cmb[0]});
            end
            tick();
            chk("vec_flags", i, {28'd0, FlagsQ}, {28'd0, v.x_flags});
            chk("vec_ctl", i, {28'd0, PCSrcM, RegWriteM, MemWriteM, MemtoRegM}, {28'd0, v.x_ctl});
            if (v.chk_dp) begin
                chk("vec_alu", i, ALUResultM, v.x_alu);
                chk("vec_wd", i, WriteDataM, v.x_wd);
                chk("vec_wa3", i, {28'd0, WA3M}, {28'd0, v.x_wa3});
            end
        end

        // Unknown bits on the unselected C,V inputs must not leak into the flags.
        drive(0, 4'hE, 2'd3, 4'b0011, 32'h0, 32'h0, 4'h0, 7'b0);
        tick();
        drive(0, 4'hE, 2'd2, 4'b100x, 32'h0, 32'h0, 4'h0, 7'b0);
        tick();
        chk("xmask_flags", 0, {28'd0, FlagsQ}, 32'h0000000B);
        chk("xmask_known", 0, {31'd0, $isunknown(FlagsQ)}, 32'h0);

        for (int f = 0; f < 16; f++) begin
            drive(0, 4'hE, 2'd3, f[3:0], 32'h0, 32'h0, 4'h0, 7'b0);
            tick();
            chk("sweep_load", f, {28'd0, FlagsQ}, f);
            for (int c = 0; c < 16; c++) begin
                drive(0, c[3:0], 2'd0, 4'h0, 32'h0, 32'h0, 4'h0, 7'b0);
                #1;
                chk("sweep_cond", f * 16 + c, {31'd0, CondExE}, {31'd0, model_cond(c[3:0], f[3:0])});
            end
        end

        drive(1, 4'h0, 2'd0, 4'h0, 32'h0, 32'h0, 4'h0, 7'b0);
        tick();
        mf = 4'h0; m_ctl = 4'h0; m_alu = 32'h0; m_wd = 32'h0; m_wa3 = 4'h0; m_dp_valid = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            logic        r_rst, r_st, r_fl, cx;
            logic [3:0]  r_cond, r_af, r_wa3;
            logic [1:0]  r_fw;
            logic [31:0] r_alu, r_wd;
            logic [4:0]  r_c;
            r_rst  = ($urandom_range(0, 39) == 0);
            r_st   = ($urandom_range(0, 3) == 0);
            r_fl   = ($urandom_range(0, 5) == 0);
            r_cond = 4'($urandom_range(0, 15));
            r_fw   = 2'($urandom_range(0, 3));
            r_af   = 4'($urandom_range(0, 15));
            r_wa3  = 4'($urandom_range(0, 15));
            r_alu  = $urandom;
            r_wd   = $urandom;
            r_c    = 5'($urandom_range(0, 31));
            drive(r_rst, r_cond, r_fw, r_af, r_alu, r_wd, r_wa3, {r_c, r_st, r_fl});
            #1;
            cx = model_cond(r_cond, mf);
            chk("rnd_condex", k, {31'd0, CondExE}, {31'd0, cx});
            chk("rnd_branch", k, {31'd0, BranchTakenE}, {31'd0, r_c[0] && cx && !r_fl});

            if (r_rst) begin
                mf = 4'h0; m_ctl = 4'h0; m_alu = 32'h0; m_wd = 32'h0; m_wa3 = 4'h0; m_dp_valid = 1'b1;
            end else begin
                if (cx && !r_st && !r_fl) begin
                    if (r_fw[1]) mf[3:2] = r_af[3:2];
                    if (r_fw[0]) mf[1:0] = r_af[1:0];
                end
                if (r_fl) begin
                    m_ctl = 4'h0;
                    m_dp_valid = 1'b0;
                end else if (!r_st) begin
                    m_ctl = {r_c[4] && cx, r_c[3] && cx, r_c[2] && cx, r_c[1]};
                    m_alu = r_alu; m_wd = r_wd; m_wa3 = r_wa3;
                    m_dp_valid = 1'b1;
                end
            end

            tick();
            chk("rnd_flags", k, {28'd0, FlagsQ}, {28'd0, mf});
            chk("rnd_ctl", k, {28'd0, PCSrcM, RegWriteM, MemWriteM, MemtoRegM}, {28'd0, m_ctl});
            if (m_dp_valid) begin
                chk("rnd_alu", k, ALUResultM, m_alu);
                chk("rnd_wd", k, WriteDataM, m_wd);
                chk("rnd_wa3", k, {28'd0, WA3M}, {28'd0, m_wa3});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cond_exec_stage.md
COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

Interface
REQ-001 SHALL have parameter N, default 32, data width of ALUResultE/WriteDataE and their M-stage copies.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port CondE  in  4  ARM condition field of the instruction in Execute.
REQ-005 SHALL have port FlagWriteE  in  2  bit1 = update N,Z; bit0 = update C,V.
REQ-006 SHALL have port ALUFlags  in  4  {N,Z,C,V} from the Execute ALU.
REQ-007 SHALL have port ALUResultE  in  N  ALU result.
REQ-008 SHALL have port WriteDataE  in  N  store data.
REQ-009 SHALL have port WA3E  in  4  destination register.
REQ-010 SHALL have ports PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE  in  1 each  decoded controls.
REQ-011 SHALL have ports StallM, FlushM  in  1 each  hazard-unit hold / bubble requests.
REQ-012 SHALL have port BranchTakenE  out  1  combinational taken-branch to fetch.
REQ-013 SHALL have port CondExE  out  1  combinational condition-pass.
REQ-014 SHALL have ports PCSrcM, RegWriteM, MemWriteM, MemtoRegM  out  1 each  registered gated controls.
REQ-015 SHALL have ports ALUResultM, WriteDataM  out  N each, and WA3M  out  4  registered datapath.
REQ-016 SHALL have port FlagsQ  out  4  current stored {N,Z,C,V}.

Function
REQ-017 SHALL hold a 4-bit flag register FlagsQ; conditions SHALL be evaluated against FlagsQ, never the same-cycle ALUFlags.
REQ-018 SHALL decode CondE: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1.
REQ-019 SHALL drive CondExE combinationally from CondE and FlagsQ; BranchTakenE = BranchE & CondExE & ~FlushM, zero cycles latency.
REQ-020 SHALL define update enable UE = CondExE & ~StallM & ~FlushM & ~reset.
REQ-021 On UE & FlagWriteE[1], N,Z SHALL load ALUFlags[3:2]; on UE & FlagWriteE[0], C,V SHALL load ALUFlags[1:0]; unselected bits SHALL hold.
REQ-022 X on ALUFlags bits not selected by FlagWriteE SHALL NOT reach FlagsQ.
REQ-023 Updated flags SHALL be visible to CondExE the cycle after the writing instruction (back-to-back CMP; BEQ needs no stall).
REQ-024 M register: on clock edge with ~StallM & ~FlushM, PCSrcM/RegWriteM/MemWriteM SHALL load PCSrcE/RegWriteE/MemWriteE each ANDed with CondExE; MemtoRegM, WA3M, ALUResultM, WriteDataM SHALL load unconditionally.
REQ-025 Latency Execute -> M outputs SHALL be exactly 1 cycle.
REQ-026 StallM high SHALL hold all M outputs and FlagsQ unchanged.
REQ-027 FlushM high SHALL clear PCSrcM, RegWriteM, MemWriteM, MemtoRegM to 0 next edge; datapath M regs MAY hold; FlagsQ SHALL hold.
REQ-028 Priority SHALL be reset > FlushM > StallM > normal load.
REQ-029 Failed condition SHALL still advance the slot (bubble-equivalent: write enables 0), never stall.

Reset
REQ-030 On reset at a rising edge, FlagsQ, all M control outputs, WA3M, ALUResultM, WriteDataM SHALL be 0.
REQ-031 With FlagsQ = 0000 after reset: EQ fails, NE passes, AL passes, GE passes.
REQ-032 Reset asserted mid-stream SHALL discard the Execute instruction; no flag or M-reg update that cycle.

Verification
REQ-033 Reset, then CondE=1110, RegWriteE=1, ALUResultE=0x0000_0005, WA3E=3 -> next cycle RegWriteM=1, ALUResultM=5, WA3M=3.
REQ-034 CMP (FlagWriteE=11, ALUFlags=0100, AL) then next cycle BranchE=1, CondE=0000 -> FlagsQ=0100, BranchTakenE=1 in second cycle.
REQ-035 FlagsQ=0100, CondE=0001, MemWriteE=1, FlagWriteE=11, ALUFlags=1000 -> MemWriteM=0, FlagsQ stays 0100.
REQ-036 FlagWriteE=10, ALUFlags=100X, FlagsQ=0011 -> FlagsQ=1011, no X.
REQ-037 StallM=1 for 2 cycles with new E inputs -> M outputs and FlagsQ unchanged; FlushM=1 with RegWriteE=1 -> RegWriteM=0, BranchTakenE=0.
REQ-038 Sweep all 16 CondE x 16 FlagsQ values -> CondExE matches REQ-018 table.
